arith_core: RTL and testbench



---
 rtl/arith_core.sv | 251 +++++++++++++++++++++++++
 tb/tb_arith_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/arith_core.sv
// ============================================================================
// arith_core
// ----------------------------------------------------------------------------
// Registered integer arithmetic core for the KGP-RISC datapath. Three
// combinational engines share one output register stage (latency = 1 cycle):
//   op 00 : hybrid adder. CLA_BLK-bit carry-lookahead blocks with the block
//           carry rippling from one block to the next.
//           {cout, result_lo} = a + b + cin, result_hi = 0
//   op 01 : unsigned array multiplier. An AND partial-product array is summed
//           by one adder row per multiplier bit.
//           {result_hi, result_lo} = a * b
//   op 10 : signed multiplier. It reuses the unsigned array and then applies
//           the two's-complement sign correction.
//           {result_hi, result_lo} = signed(a) * signed(b)
//   op 11 : reserved. All results are 0, but out_valid still asserts.
//
// Optional build macro: ARITH_FLAGS_EN
//   When defined, the core adds the registered status outputs zflag, sflag,
//   vflag and cflag.
//
// Parameters:
//   WIDTH    operand width (product width is 2*WIDTH)
//   CLA_BLK  lookahead block width inside the adder; must divide WIDTH
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operands and op are valid this cycle
//   op         operation select (see above)
//   a, b       operands
//   cin        adder carry-in (used only by op 00)
//   out_valid  the result registers were updated by the last edge
//   result_lo  sum, or the low half of the product
//   result_hi  zero for add, or the high half of the product
//   cout       adder carry-out (add only, otherwise 0)
//   zflag      result is zero; 64-bit for multiplies        [ARITH_FLAGS_EN]
//   sflag      sign of the sum (add only)                   [ARITH_FLAGS_EN]
//   vflag      signed overflow of the add                   [ARITH_FLAGS_EN]
//   cflag      copy of cout                                 [ARITH_FLAGS_EN]
// ============================================================================
module arith_core #(
    parameter int WIDTH   = 32,
    parameter int CLA_BLK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             cout
`ifdef ARITH_FLAGS_EN
    ,
    output logic             zflag,
    output logic             sflag,
    output logic             vflag,
    output logic             cflag
`endif
);

    localparam int NBLK = WIDTH / CLA_BLK;
    localparam int PW   = 2 * WIDTH;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_UMUL = 2'b01,
        OP_SMUL = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    op_e op_sel;
    assign op_sel = op_e'(op);

    // ------------------------------------------------------------------------
    // Hybrid adder
    // ------------------------------------------------------------------------
    // cin is masked for all ops except add. An unused (possibly X) carry-in
    // therefore never reaches the datapath.
    logic             add_cin;
    logic [WIDTH-1:0] sum;
    logic             add_cout;

    assign add_cin = (op_sel == OP_ADD) ? cin : 1'b0;

    for (genvar k = 0; k < NBLK; k++) begin : g_cla
        logic [CLA_BLK-1:0] x, y, g, p;
        logic [CLA_BLK:0]   c;
        logic               ci;
        logic               co;

        assign x = a[k*CLA_BLK +: CLA_BLK];
        assign y = b[k*CLA_BLK +: CLA_BLK];
        assign g = x & y;
        assign p = x ^ y;

        // The block carry-in comes from the previous block. Each block has its
        // own signal so the carry chain is not one self-referencing vector.
        if (k == 0) begin : g_first
            assign ci = add_cin;
        end else begin : g_chain
            assign ci = g_cla[k-1].co;
        end

        // Full lookahead inside the block:
        //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci
        // pchain holds the product of the propagate terms above bit j.
        always_comb begin
            logic cn;
            logic pchain;
            c[0] = ci;
            for (int i = 0; i < CLA_BLK; i++) begin
                cn     = 1'b0;
                pchain = 1'b1;
                for (int j = i; j >= 0; j--) begin
                    cn     = cn | (g[j] & pchain);
                    pchain = pchain & p[j];
                end
                c[i+1] = cn | (pchain & ci);
            end
        end

        assign sum[k*CLA_BLK +: CLA_BLK] = p ^ c[CLA_BLK-1:0];
        assign co = c[CLA_BLK];
    end

    assign add_cout = g_cla[NBLK-1].co;

    // ------------------------------------------------------------------------
    // Unsigned array multiplier
    // ------------------------------------------------------------------------
    // Row i adds the partial product (a AND b[i]), shifted left by i, to the
    // running sum from row i-1. The last row holds the full 2*WIDTH product.
    for (genvar i = 0; i < WIDTH; i++) begin : g_row
        logic [PW-1:0] pp;
        logic [PW-1:0] acc;

        assign pp = {{WIDTH{1'b0}}, a & {WIDTH{b[i]}}} << i;

        if (i == 0) begin : g_first
            assign acc = pp;
        end else begin : g_add
            assign acc = g_row[i-1].acc + pp;
        end
    end

    logic [PW-1:0] uprod;
    assign uprod = g_row[WIDTH-1].acc;

    // ------------------------------------------------------------------------
    // Signed product by sign correction of the unsigned product
    // ------------------------------------------------------------------------
    // signed(a) = a - a[MSB]*2^W, and the same holds for b. Expanding the
    // product gives:
    //   signed(a)*signed(b) = a*b - a[MSB]*b*2^W - b[MSB]*a*2^W   (mod 2^2W)
    // The a[MSB]*b[MSB]*2^2W term drops out modulo 2^2W. That is why the
    // most-negative square comes out as a correct positive value.
    logic [PW-1:0] corr_a;
    logic [PW-1:0] corr_b;
    logic [PW-1:0] sprod;

    assign corr_a = {b & {WIDTH{a[WIDTH-1]}}, {WIDTH{1'b0}}};
    assign corr_b = {a & {WIDTH{b[WIDTH-1]}}, {WIDTH{1'b0}}};
    assign sprod  = uprod - corr_a - corr_b;

    // ------------------------------------------------------------------------
    // Result select
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] nxt_lo;
    logic [WIDTH-1:0] nxt_hi;
    logic             nxt_cout;

    // NOTE: every output of a combinational block gets a default before the
    // case statement. A path that misses an assignment would otherwise infer
    // a latch. The default arm also turns an X or reserved op into zeros.
    always_comb begin
        nxt_lo   = '0;
        nxt_hi   = '0;
        nxt_cout = 1'b0;
        case (op_sel)
            OP_ADD: begin
                nxt_lo   = sum;
                nxt_cout = add_cout;
            end
            OP_UMUL: {nxt_hi, nxt_lo} = uprod;
            OP_SMUL: {nxt_hi, nxt_lo} = sprod;
            default: ;
        endcase
    end

`ifdef ARITH_FLAGS_EN
    logic nxt_z;
    logic nxt_s;
    logic nxt_v;

    always_comb begin
        nxt_z = 1'b0;
        nxt_s = 1'b0;
        nxt_v = 1'b0;
        case (op_sel)
            OP_UMUL, OP_SMUL: nxt_z = ({nxt_hi, nxt_lo} == '0);
            OP_ADD: begin
                nxt_z = (nxt_lo == '0);
                nxt_s = nxt_lo[WIDTH-1];
                // The carry into the MSB XOR the carry out of the MSB.
                nxt_v = a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH-1] ^ add_cout;
            end
            default: nxt_z = (nxt_lo == '0);
        endcase
    end
`endif

    // ------------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples the pre-edge values, whatever order the
    // statements are written in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            cout      <= 1'b0;
`ifdef ARITH_FLAGS_EN
            zflag     <= 1'b1;
            sflag     <= 1'b0;
            vflag     <= 1'b0;
            cflag     <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            // Results hold their last value while in_valid is low.
            if (in_valid) begin
                result_lo <= nxt_lo;
                result_hi <= nxt_hi;
                cout      <= nxt_cout;
`ifdef ARITH_FLAGS_EN
                zflag     <= nxt_z;
                sflag     <= nxt_s;
                vflag     <= nxt_v;
                cflag     <= nxt_cout;
`endif
            end
        end
    end

endmodule

// File: tb/tb_arith_core.sv
// ============================================================================
// tb_arith_core
// ----------------------------------------------------------------------------
// Self-checking bench for arith_core. A behavioural reference model computes
// every cycle's expected outputs with plain wide integer arithmetic. Directed
// cases also compare against literal constants. Prints one summary line.
// ============================================================================
module tb_arith_core;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic [W-1:0] result_lo;
    logic [W-1:0] result_hi;
    logic         cout;
`ifdef ARITH_FLAGS_EN
    logic         zflag, sflag, vflag, cflag;
`endif

    arith_core #(.WIDTH(W), .CLA_BLK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .cout      (cout)
`ifdef ARITH_FLAGS_EN
        ,
        .zflag     (zflag),
        .sflag     (sflag),
        .vflag     (vflag),
        .cflag     (cflag)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic         m_valid;
    logic [W-1:0] m_lo, m_hi;
    logic         m_cout;
    logic         m_z, m_s, m_v;

    task automatic model_step(input logic r, input logic v, input logic [1:0] o,
                              input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0]  s;
        logic [63:0] prod;
        longint      sx, sy, ssum;
        if (!r) begin
            m_valid = 1'b0; m_lo = '0; m_hi = '0; m_cout = 1'b0;
            m_z = 1'b1; m_s = 1'b0; m_v = 1'b0;
            return;
        end
        m_valid = v;
        if (!v) return;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        m_s = 1'b0; m_v = 1'b0; m_cout = 1'b0;
        case (o)
            2'd0: begin
                s      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
                m_lo   = s[W-1:0];
                m_hi   = '0;
                m_cout = s[W];
                ssum   = sx + sy + longint'(ci);
                m_v    = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
                m_s    = m_lo[W-1];
                m_z    = (m_lo == 0);
            end
            2'd1: begin
                prod = 64'(x) * 64'(y);
                {m_hi, m_lo} = prod;
                m_z = (prod == 0);
            end
            2'd2: begin
                prod = 64'(sx * sy);
                {m_hi, m_lo} = prod;
                m_z = (prod == 0);
            end
            default: begin
                m_lo = '0; m_hi = '0; m_z = 1'b1;
            end
        endcase
    endtask

    task automatic compare_model();
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("result_lo", 64'(result_lo), 64'(m_lo));
        check("result_hi", 64'(result_hi), 64'(m_hi));
        check("cout",      64'(cout),      64'(m_cout));
`ifdef ARITH_FLAGS_EN
        check("zflag", 64'(zflag), 64'(m_z));
        check("sflag", 64'(sflag), 64'(m_s));
        check("vflag", 64'(vflag), 64'(m_v));
        check("cflag", 64'(cflag), 64'(m_cout));
`endif
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the edge.
    task automatic step(input logic r, input logic v, input logic [1:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        rst_n = r; in_valid = v; op = o; a = x; b = y; cin = ci;
        @(posedge clk);
        #1;
        model_step(r, v, o, x, y, ci);
        compare_model();
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [W-1:0] hi,
                              input logic [W-1:0] lo, input logic c);
        check({tag, "_valid"}, 64'(out_valid), 64'(v));
        check({tag, "_hi"},    64'(result_hi), 64'(hi));
        check({tag, "_lo"},    64'(result_lo), 64'(lo));
        check({tag, "_cout"},  64'(cout),      64'(c));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        // Reset with a live operation on the inputs; it must be discarded.
        step(1'b0, 1'b1, 2'd0, 32'd5, 32'd7, 1'b0);
        step(1'b0, 1'b1, 2'd0, 32'd5, 32'd7, 1'b0);
        expect_out("reset", 1'b0, 32'h0, 32'h0, 1'b0);
`ifdef ARITH_FLAGS_EN
        check("reset_zflag", 64'(zflag), 64'd1);
`endif

        // Add wrap and signed overflow
        step(1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        expect_out("add_wrap", 1'b1, 32'h0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 2'd0, 32'h7FFF_FFFF, 32'h1, 1'b0);
        expect_out("add_ovf", 1'b1, 32'h0, 32'h8000_0000, 1'b0);
`ifdef ARITH_FLAGS_EN
        check("add_ovf_vflag", 64'(vflag), 64'd1);
`endif

        // Unsigned multiply
        step(1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        expect_out("umul_max", 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        step(1'b1, 1'b1, 2'd1, 32'h0001_0000, 32'h0001_0000, 1'b0);
        expect_out("umul_2p32", 1'b1, 32'h1, 32'h0, 1'b0);

        // Signed multiply
        step(1'b1, 1'b1, 2'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
        expect_out("smul_m2x3", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        step(1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        expect_out("smul_m1sq", 1'b1, 32'h0, 32'h1, 1'b0);
        step(1'b1, 1'b1, 2'd2, 32'h8000_0000, 32'h8000_0000, 1'b0);
        expect_out("smul_minsq", 1'b1, 32'h4000_0000, 32'h0, 1'b0);

        // Reserved op
        step(1'b1, 1'b1, 2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        expect_out("reserved", 1'b1, 32'h0, 32'h0, 1'b0);

        // Back-to-back, then hold
        step(1'b1, 1'b1, 2'd0, 32'd2, 32'd3, 1'b1);
        expect_out("b2b_add", 1'b1, 32'h0, 32'd6, 1'b0);
        step(1'b1, 1'b1, 2'd1, 32'd6, 32'd7, 1'b0);
        expect_out("b2b_umul", 1'b1, 32'h0, 32'd42, 1'b0);
        step(1'b1, 1'b1, 2'd2, 32'hFFFF_FFFC, 32'd5, 1'b0);
        expect_out("b2b_smul", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 1'b0);
        step(1'b1, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'h1, 1'b1);
        expect_out("hold1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 1'b0);
        step(1'b1, 1'b0, 2'd1, 32'h5555_5555, 32'h3, 1'b0);
        expect_out("hold2", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 1'b0);

        // Reset mid-stream
        step(1'b1, 1'b1, 2'd0, 32'd100, 32'd1, 1'b0);
        expect_out("mid_first", 1'b1, 32'h0, 32'd101, 1'b0);
        step(1'b0, 1'b1, 2'd1, 32'd9, 32'd9, 1'b0);
        expect_out("mid_lost", 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 2'd1, 32'd9, 32'd9, 1'b0);
        expect_out("mid_after", 1'b1, 32'h0, 32'd81, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
